// File: rtl/rr_hold_arbiter_pkg.sv
// Shared types, field positions and helpers for the round-robin hold arbiter.
// Owner index width is fixed at 2 bits because there are exactly four requesters.
package rr_hold_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 8;
    localparam int OUT_W   = 8;

    localparam int VALID_BIT   = 7;
    localparam int OWNER_LSB   = 5;
    localparam int PREEMPT_BIT = 4;
    localparam int ONEHOT_LSB  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // The one-hot field is always derived from the owner index, so the two fields can never disagree.
    function automatic logic [OUT_W-1:0] pack_grant(input logic [IDX_W-1:0] idx,
                                                    input logic             preempt);
        logic [OUT_W-1:0] word;
        word                          = '0;
        word[VALID_BIT]               = 1'b1;
        word[OWNER_LSB +: IDX_W]      = idx;
        word[PREEMPT_BIT]             = preempt;
        word[ONEHOT_LSB +: NUM_REQ]   = idx_to_onehot(idx);
        return word;
    endfunction

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational four-way round-robin selector.
// It returns the first unmasked request found when scanning upward from i_start and wrapping.
module rr_pick
    import rr_hold_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_eff;

    assign w_eff = i_req & ~i_mask;

    // The scan runs from farthest to nearest, so the candidate closest to i_start is written last and wins.
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        // NOTE: every output and local variable gets a default first, otherwise always_comb infers a latch
        w_cand  = '0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = i_start + IDX_W'(i);
            if (w_eff[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter granting one of four requesters exclusive ownership until release or hold-limit preemption.
// All outputs come from one registered word.
module rr_hold_arbiter
    import rr_hold_arbiter_pkg::*;
(
    input  logic               _i_clk,
    input  logic               _i_rst,
    input  logic [NUM_REQ-1:0] _i_req,
    input  logic               _i_release,
    input  logic [HOLD_W-1:0]  _i_max_hold,
    output logic [OUT_W-1:0]   __output
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [HOLD_W-1:0]  r_hold;
    logic [OUT_W-1:0]   r_out;

    logic [NUM_REQ-1:0] w_owner_1h;
    logic [NUM_REQ-1:0] w_mask;
    logic [IDX_W-1:0]   w_start;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_timeout;
    logic               w_others;
    logic               w_preempt;
    logic               w_end;

    assign w_owner_1h = idx_to_onehot(r_owner);
    assign w_timeout  = (r_hold >= _i_max_hold);
    assign w_others   = |(_i_req & ~w_owner_1h);
    // A release takes priority over a timeout in the same cycle, so no preempt pulse is raised then.
    assign w_preempt  = (r_state == GRANT) && !_i_release && w_timeout && w_others;
    assign w_end      = (r_state == GRANT) && (_i_release || w_preempt);

    // On release the owner stays eligible but is scanned last; on preemption it is excluded.
    assign w_start = (r_state == IDLE) ? r_ptr : r_owner + IDX_W'(1);
    assign w_mask  = (r_state == GRANT && !_i_release) ? w_owner_1h : '0;

    rr_pick u_pick (
        .i_req   (_i_req),
        .i_mask  (w_mask),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_hold  <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_owner <= w_pick;
                        r_hold  <= '0;
                        r_out   <= pack_grant(w_pick, 1'b0);
                    end
                end
                GRANT: begin
                    if (w_end) begin
                        r_ptr <= r_owner + IDX_W'(1);
                        if (w_found) begin
                            r_owner <= w_pick;
                            r_hold  <= '0;
                            r_out   <= pack_grant(w_pick, w_preempt);
                        end else begin
                            r_state <= IDLE;
                            r_out   <= '0;
                        end
                    end else begin
                        // The hold count saturates; an uncontested owner keeps the grant indefinitely.
                        if (!w_timeout) begin
                            r_hold <= r_hold + HOLD_W'(1);
                        end
                        r_out[PREEMPT_BIT] <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign __output = r_out;

endmodule
